debug_uart_arbiter: RTL
=======================

// Module: debug_uart_arbiter
// PURPOSE
//  Shares the single debug UART transmitter (uart_tx instance driving DEBUG_UART_TX) between
//  NUM_SRC telemetry sources (e.g. gyro samples, RC channel dump, PID state). Frame-level
//  round-robin: a granted source holds the UART until its last byte. Optional header byte
//  tags each frame with the source id. Sits in flight between the producers and uart_tx.
// PARAMETERS
//  NUM_SRC      4      number of requesters, 2..16
//  HDR_EN       1      1: send header byte {HDR_TAG, src_id[3:0]} before each frame
//  HDR_TAG      4'hA   upper nibble of the header byte
//  GAP_TIMEOUT  1024   max idle cycles mid-frame waiting for the granted src_valid
// PORTS
//  clock        in   1           system clock
//  reset        in   1           synchronous, active-high
//  src_valid    in   NUM_SRC     source i has a byte on src_data[8i+7:8i]
//  src_data     in   8*NUM_SRC   byte per source
//  src_last     in   NUM_SRC     byte is the last byte of its frame
//  src_ready    out  NUM_SRC     one-cycle accept pulse; byte consumed when valid&ready
//  grant        out  NUM_SRC     one-hot owner of the UART, 0 when idle
//  busy         out  1           high whenever state != IDLE
//  timeout_err  out  1           one-cycle pulse when a frame is aborted by GAP_TIMEOUT
//  tx_send      out  1           one-cycle pulse to uart_tx.send
//  tx_data      out  8           to uart_tx.txIn, stable from tx_send until back in FETCH/IDLE
//  tx_idle      in   1           uart_tx.sendComplete: low while shifting, high when idle
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer last_grant = NUM_SRC-1 (src 0 wins first).
//  States: IDLE, HDR, FETCH, SEND, WAIT_BUSY, WAIT_IDLE.
//  IDLE: if any src_valid -> pick first set bit scanning from (last_grant+1) mod NUM_SRC;
//   register grant; go HDR (HDR_EN=1) else FETCH. No valid -> stay.
//  HDR: tx_data <= {HDR_TAG, id}; last_lat <= 0; -> SEND.
//  FETCH: src_ready[g] = src_valid[g] (combinational, only in FETCH); on accept tx_data <=
//   byte, last_lat <= src_last[g], gap counter cleared, -> SEND. Else gap counter +1; on
//   reaching GAP_TIMEOUT: timeout_err pulse, last_grant <= g, grant <= 0, -> IDLE.
//  SEND: tx_send = 1 for exactly this cycle -> WAIT_BUSY.
//  WAIT_BUSY: wait for tx_idle==0 (transmitter started) -> WAIT_IDLE. Waits indefinitely;
//   never re-pulses tx_send.
//  WAIT_IDLE: on tx_idle==1: last_lat ? (last_grant <= g, grant <= 0, -> IDLE) : -> FETCH.
//  Latency: src_valid seen in IDLE at cycle N -> grant at N+1; HDR_EN=0: src_ready at N+1,
//   tx_send at N+2; HDR_EN=1: header tx_send at N+2.
//  No preemption: other sources' valid ignored while granted; src_ready for non-granted = 0.
//  Simultaneous requests resolved purely by rr order; rr pointer moves only on frame end
//   or timeout, so a source re-requesting immediately goes to the back of the queue.
//  Single-byte frame (valid&last on first fetch) legal. src_last sampled only on accept.
//  Gap counter 16-bit saturating-free; counts only in FETCH.
//  Reset mid-frame: next edge returns to reset state; byte already in uart_tx completes on
//   the line but is not tracked; source frame is simply truncated.
// TESTING (bench drives a behavioural uart_tx: tx_idle low 2 cycles after send, 10 cycles busy)
//  1. HDR_EN=1, src2 frame 11,22,33 (last on 33) -> line bytes A2,11,22,33; 3 src_ready
//     pulses on src2; grant=0100 throughout, 0 after; busy falls after final tx_idle rise.
//  2. src0 and src3 assert valid same cycle after reset -> src0 full frame first, then src3;
//     src0 re-asserting during src3 frame not serviced until src3 last byte done.
//  3. All 4 sources stream continuous 1-byte frames -> grant order 0,1,2,3,0,1; 4 frames
//     each over 16 frames, no starvation.
//  4. GAP_TIMEOUT=16: src1 sends 1 byte (no last) then drops valid -> timeout_err 1 cycle
//     exactly 16 FETCH cycles later; grant=0; next frame goes to src2 if pending.
//  5. Assert reset during WAIT_IDLE of byte 2 -> next cycle grant/busy/tx_send/src_ready=0;
//     subsequent request from src3 with src0 pending -> src0 granted first.
//  6. Model holds tx_idle high after tx_send -> block stays WAIT_BUSY, exactly one tx_send,
//     no src_ready; releasing model completes frame normally.

Source files
------------

// File: rtl/debug_uart_arbiter_if.sv
// debug_uart_arbiter_if
//  Bundles the byte-stream handshake between the telemetry sources and the
//  arbiter, plus the send/data/idle link between the arbiter and uart_tx.
//  Ports (signals):
//   src_valid [NUM_SRC]    source i has a byte on src_data[8i+7:8i]
//   src_data  [8*NUM_SRC]  one byte per source
//   src_last  [NUM_SRC]    byte closes its frame
//   src_ready [NUM_SRC]    accept pulse from the arbiter
//   tx_send                one-cycle send strobe to uart_tx
//   tx_data   [8]          byte to uart_tx
//   tx_idle                uart_tx not shifting
//  master: producer/transmitter side.  slave: the arbiter.
interface debug_uart_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   src_valid;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 tx_send;
    logic [7:0]           tx_data;
    logic                 tx_idle;

    modport master (
        output src_valid, src_data, src_last, tx_idle,
        input  src_ready, tx_send, tx_data
    );

    modport slave (
        input  src_valid, src_data, src_last, tx_idle,
        output src_ready, tx_send, tx_data
    );
endinterface

// File: rtl/debug_uart_arbiter.sv
// debug_uart_arbiter
//  Shares one debug uart_tx between NUM_SRC telemetry sources. Arbitration is
//  frame-level round-robin: the granted source owns the transmitter until its
//  last byte has left the shifter. An optional header byte {HDR_TAG, id}
//  precedes every frame. A stalled frame is abandoned after GAP_TIMEOUT idle
//  FETCH cycles.
//  Ports:
//   clock        system clock
//   reset        synchronous, active-high
//   bus          slave side of debug_uart_arbiter_if (sources + uart_tx link)
//   grant        one-hot current owner, 0 when idle
//   busy         high whenever the FSM is not IDLE
//   timeout_err  one-cycle pulse when a frame is abandoned
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | no owner; round-robin pick among valid sources
//  HDR       | load header byte {HDR_TAG, id} into tx_data
//  FETCH     | offer src_ready to the owner; latch byte and last flag
//  SEND      | one-cycle tx_send strobe
//  WAIT_BUSY | wait for uart_tx to leave idle (start of shifting)
//  WAIT_IDLE | wait for uart_tx to finish; end frame or fetch next byte
module debug_uart_arbiter #(
    parameter int         NUM_SRC     = 4,
    parameter bit         HDR_EN      = 1'b1,
    parameter logic [3:0] HDR_TAG     = 4'hA,
    parameter int         GAP_TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    debug_uart_arbiter_if.slave  bus,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int          ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [15:0] GAP_LOAD = 16'(GAP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, HDR, FETCH, SEND, WAIT_BUSY, WAIT_IDLE
    } state_t;

    state_t          state, state_n;
    logic [ID_W-1:0] gnt_id, last_grant, pick_id;
    logic            pick_found;
    logic            accept, gap_expired, frame_done;
    logic            last_lat;
    logic [7:0]      tx_data_q;
    logic [15:0]     gap_cnt;
    logic            sel_valid, sel_last;
    logic [7:0]      sel_data;

    // Round-robin pick: walk offsets from NUM_SRC down to 1 so the smallest
    // offset after last_grant is the one left standing.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (bus.src_valid[ID_W'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // Owner's byte lane.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_valid = bus.src_valid[i];
                sel_last  = bus.src_last[i];
                sel_data  = bus.src_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_n       = state;
        accept        = 1'b0;
        gap_expired   = 1'b0;
        frame_done    = 1'b0;
        bus.src_ready = '0;
        bus.tx_send   = 1'b0;
        timeout_err   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) state_n = HDR_EN ? HDR : FETCH;
            end
            HDR: begin
                state_n = SEND;
            end
            FETCH: begin
                bus.src_ready = sel_valid ? grant : '0;
                if (sel_valid) begin
                    accept  = 1'b1;
                    state_n = SEND;
                end else if (gap_cnt == 16'd0) begin
                    gap_expired = 1'b1;
                    timeout_err = 1'b1;
                    state_n     = IDLE;
                end
            end
            SEND: begin
                bus.tx_send = 1'b1;
                state_n     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.tx_idle) state_n = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (bus.tx_idle) begin
                    if (last_lat) begin
                        frame_done = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // gap_cnt is a down-counter: loaded with GAP_TIMEOUT-1 at frame start and
    // on every accepted byte, so terminal count 0 is hit on the GAP_TIMEOUT-th
    // consecutive FETCH cycle without a byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            gnt_id     <= '0;
            last_grant <= ID_W'(NUM_SRC - 1);
            last_lat   <= 1'b0;
            tx_data_q  <= '0;
            gap_cnt    <= GAP_LOAD;
        end else begin
            state <= state_n;
            if (state == IDLE && pick_found) begin
                gnt_id  <= pick_id;
                grant   <= NUM_SRC'(1) << pick_id;
                gap_cnt <= GAP_LOAD;
            end
            if (state == HDR) begin
                tx_data_q <= {HDR_TAG, 4'(gnt_id)};
                last_lat  <= 1'b0;
            end
            if (accept) begin
                tx_data_q <= sel_data;
                last_lat  <= sel_last;
                gap_cnt   <= GAP_LOAD;
            end else if (state == FETCH && !gap_expired) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
            // The rr pointer only moves when a frame ends or is abandoned.
            if (gap_expired || frame_done) begin
                last_grant <= gnt_id;
                grant      <= '0;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign bus.tx_data = tx_data_q;
endmodule
